// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: handshake bundle between the capture session controller
// and its surroundings (run button, LA core, UART streamer, debug taps).
// slave  = the sequencer side, master = the side that drives the requests.
interface capture_sequencer_if;
    logic       btn_run_pulse;
    logic       single_shot;
    logic       capture_done;
    logic       uart_busy;
    logic       uart_done;
    logic       trigger_enable;
    logic       uart_start;
    logic       clear_done;
    logic [2:0] seq_state;
    logic [7:0] capture_count;
    logic       readout_error;

    modport slave (
        input  btn_run_pulse, single_shot, capture_done, uart_busy, uart_done,
        output trigger_enable, uart_start, clear_done, seq_state, capture_count,
        readout_error
    );

    modport master (
        output btn_run_pulse, single_shot, capture_done, uart_busy, uart_done,
        input  trigger_enable, uart_start, clear_done, seq_state, capture_count,
        readout_error
    );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: session controller for the logic-analyzer core, BRAM and
// UART streamer: arm -> capture_done -> UART dump -> uart_done -> release core
// -> holdoff -> re-arm (or stop after one readout in single-shot mode).
// Optional feature macro: CAPSEQ_READOUT_TIMEOUT_EN adds a readout watchdog
// (TIMEOUT_CYCLES parameter, sticky readout_error). Without it readout waits
// forever and readout_error is tied low.
// All outputs are registered; pulses appear the cycle after the decision.
module capture_sequencer #(
    parameter logic [19:0] HOLDOFF_CYCLES = 20'd50_000
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    capture_sequencer_if.slave   bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARMED    = 3'd1;
    localparam logic [2:0] ST_READ_REQ = 3'd2;
    localparam logic [2:0] ST_READOUT  = 3'd3;
    localparam logic [2:0] ST_HOLDOFF  = 3'd4;

    logic [2:0]  state_r, state_s;
    logic        trigger_enable_r, trigger_enable_s;
    logic        uart_start_r, uart_start_s;
    logic        clear_done_r, clear_done_s;
    logic [7:0]  capture_count_r, capture_count_s;
    logic        stop_pending_r, stop_pending_s;
    logic [19:0] holdoff_cnt_r, holdoff_cnt_s;
    logic        capture_done_d1_r;
    logic        uart_done_d1_r;
    logic        cd_rise_s;
    logic        ud_rise_s;
    logic        stop_now_s;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
    logic [23:0] timeout_cnt_r, timeout_cnt_s;
    logic        readout_error_r, readout_error_s;
`endif

    assign cd_rise_s = bus.capture_done & ~capture_done_d1_r;
    assign ud_rise_s = bus.uart_done & ~uart_done_d1_r;

    // Next-state and next-output decode for the session FSM.
    always_comb begin
        state_s          = state_r;
        trigger_enable_s = 1'b0;
        uart_start_s     = 1'b0;
        clear_done_s     = 1'b0;
        capture_count_s  = capture_count_r;
        stop_pending_s   = stop_pending_r;
        holdoff_cnt_s    = holdoff_cnt_r;
        stop_now_s       = stop_pending_r | bus.btn_run_pulse;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
        timeout_cnt_s    = timeout_cnt_r;
        readout_error_s  = readout_error_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.btn_run_pulse) begin
                    state_s          = ST_ARMED;
                    trigger_enable_s = 1'b1;
                    stop_pending_s   = 1'b0;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
                    readout_error_s  = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // A capture arriving with a stop request still gets dumped.
                if (cd_rise_s) begin
                    state_s        = ST_READ_REQ;
                    stop_pending_s = stop_now_s;
                end else if (bus.btn_run_pulse) begin
                    state_s = ST_IDLE;
                end else begin
                    trigger_enable_s = 1'b1;
                end
            end
            ST_READ_REQ: begin
                stop_pending_s = stop_now_s;
                if (!bus.uart_busy) begin
                    state_s      = ST_READOUT;
                    uart_start_s = 1'b1;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
                    timeout_cnt_s = 24'd0;
`endif
                end else begin
                    state_s = ST_READ_REQ;
                end
            end
            ST_READOUT: begin
                if (ud_rise_s) begin
                    clear_done_s    = 1'b1;
                    capture_count_s = capture_count_r + 8'd1;
                    stop_pending_s  = 1'b0;
                    if (stop_now_s || bus.single_shot) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s       = ST_HOLDOFF;
                        holdoff_cnt_s = HOLDOFF_CYCLES;
                    end
                end
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
                else if (({1'b0, timeout_cnt_r} + 25'd1) >= {1'b0, TIMEOUT_CYCLES}) begin
                    clear_done_s    = 1'b1;
                    readout_error_s = 1'b1;
                    stop_pending_s  = 1'b0;
                    state_s         = ST_IDLE;
                end
`endif
                else begin
                    stop_pending_s = stop_now_s;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
                    timeout_cnt_s  = timeout_cnt_r + 24'd1;
`endif
                end
            end
            ST_HOLDOFF: begin
                // Counter value 0 or 1 both mean the last holdoff cycle.
                if (bus.btn_run_pulse) begin
                    state_s = ST_IDLE;
                end else if (holdoff_cnt_r <= 20'd1) begin
                    state_s          = ST_ARMED;
                    trigger_enable_s = 1'b1;
                end else begin
                    holdoff_cnt_s = holdoff_cnt_r - 20'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, output and edge-detect registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r           <= ST_IDLE;
            trigger_enable_r  <= 1'b0;
            uart_start_r      <= 1'b0;
            clear_done_r      <= 1'b0;
            capture_count_r   <= 8'd0;
            stop_pending_r    <= 1'b0;
            holdoff_cnt_r     <= 20'd0;
            capture_done_d1_r <= 1'b0;
            uart_done_d1_r    <= 1'b0;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
            timeout_cnt_r     <= 24'd0;
            readout_error_r   <= 1'b0;
`endif
        end else begin
            state_r           <= state_s;
            trigger_enable_r  <= trigger_enable_s;
            uart_start_r      <= uart_start_s;
            clear_done_r      <= clear_done_s;
            capture_count_r   <= capture_count_s;
            stop_pending_r    <= stop_pending_s;
            holdoff_cnt_r     <= holdoff_cnt_s;
            capture_done_d1_r <= bus.capture_done;
            uart_done_d1_r    <= bus.uart_done;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
            timeout_cnt_r     <= timeout_cnt_s;
            readout_error_r   <= readout_error_s;
`endif
        end
    end

    assign bus.trigger_enable = trigger_enable_r;
    assign bus.uart_start     = uart_start_r;
    assign bus.clear_done     = clear_done_r;
    assign bus.seq_state      = state_r;
    assign bus.capture_count  = capture_count_r;
`ifdef CAPSEQ_READOUT_TIMEOUT_EN
    assign bus.readout_error  = readout_error_r;
`else
    assign bus.readout_error  = 1'b0;
`endif

endmodule
